cpu_control_unit: RTL and testbench
===================================

Name: cpu_control_unit

Overview:
- Multi-cycle fetch/execute controller for the simple CPU; the stage directly upstream of the 16x4 data memory.
- Fetches 12-bit instructions from an external combinational instruction ROM.
- Holds the PC, an 8x4 register file and a 4-bit ALU.
- Drives the data memory's address, write_data, write_enable and read_enable ports, and consumes its registered read_data.

Parameters:
- DATA_WIDTH, 4: width of registers, ALU and data memory word; must match data memory.
- ADDR_WIDTH, 4: data memory address width; must match data memory.
- PC_WIDTH, 4: program counter width; ROM depth is 2**PC_WIDTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; shared with data memory.
- start  input  1  level; begins execution from IDLE.
- instr  input  12  ROM word at address pc (combinational ROM).
- pc  output  PC_WIDTH  current program counter.
- dm_address  output  ADDR_WIDTH  data memory address.
- dm_write_data  output  DATA_WIDTH  data memory write data.
- dm_write_enable  output  1  data memory write strobe.
- dm_read_enable  output  1  data memory read strobe.
- dm_read_data  input  DATA_WIDTH  data memory registered read data.
- dbg_sel  input  3  register index for debug readout.
- dbg_data  output  DATA_WIDTH  combinational value of regs[dbg_sel].
- halted  output  1  high while in HALT state.

Behaviour:
- Reset: state=IDLE, pc=0, IR=0, all 8 registers=0, halted=0.
- Whenever reset=1, dm_write_enable and dm_read_enable are forced to 0 combinationally.
- Instruction format: op=instr[11:9], rd=[8:6], rs1=[5:3], rs2=[2:0], addr/imm=[3:0].
- Opcodes:
  - 000 NOP.
  - 001 LOAD rd<=mem[addr].
  - 010 STORE mem[addr]<=rd.
  - 011 ADD rd<=rs1+rs2.
  - 100 SUB rd<=rs1-rs2.
  - 101 LDI rd<=imm.
  - 111 HALT.
  - 110 executes as NOP.
- Arithmetic: modulo 2**DATA_WIDTH; carry/borrow discarded, no flags.
- State IDLE: no memory strobes; start=1 -> FETCH.
- State FETCH: IR<=instr, pc<=pc+1 (wraps 15->0) -> EXEC.
- State EXEC, by opcode:
  - ADD/SUB/LDI: write rd this edge -> FETCH. Two cycles per instruction.
  - NOP: -> FETCH.
  - STORE: dm_write_enable=1, dm_address=IR[3:0], dm_write_data=regs[rd] for exactly this cycle -> FETCH.
  - LOAD: dm_read_enable=1, dm_address=IR[3:0] for exactly this cycle -> MEM_WAIT.
  - HALT: -> HALT.
- State MEM_WAIT: regs[rd]<=dm_read_data (memory latched it on the EXEC edge) -> FETCH. LOAD takes three cycles.
- State HALT: halted=1; pc frozen; no strobes; remains until reset. start ignored.
- Strobe rules:
  - dm_read_enable and dm_write_enable are never high in the same cycle.
  - Both are 0 in IDLE, FETCH, MEM_WAIT and HALT.
- dm_address and dm_write_data are 0 whenever no strobe is asserted.
- start is ignored outside IDLE; deasserting start mid-program has no effect.
- Memory init: the data memory clears itself on the first clock after power-up/reset. IDLE lasts at least one cycle after reset, so the first strobe never coincides with that clear.
- Reset mid-operation: a reset on any cycle, including the EXEC of a STORE, has these effects:
  - no write reaches memory;
  - the controller returns to IDLE next cycle with all state cleared.
- Register writes:
  - rd=0 is an ordinary register (no hardwired zero).
  - Reads of a register in the instruction that writes it return the old value.
- PC wrap: a program with no HALT runs 15 -> 0 and continues indefinitely.

Test Plan:
- LDI/ADD: ROM = LDI r1,9; LDI r2,8; ADD r3,r1,r2; HALT; pulse start -> regs[3]=1 (wrap), halted=1 after 8 cycles from FETCH, pc=4.
- SUB wrap: LDI r1,2; LDI r2,5; SUB r0,r1,r2; HALT -> regs[0]=13.
- STORE/LOAD round trip: LDI r4,0xA; STORE r4,[7]; LOAD r5,[7]; HALT. Check:
  - exactly one write cycle with addr=7, data=0xA;
  - one read cycle with addr=7;
  - no overlapping strobes;
  - regs[5]=0xA.
- LOAD of untouched address after reset: LOAD r6,[3] -> regs[6]=0 (memory cleared); LOAD spans three cycles.
- Reset mid-STORE: assert reset during the EXEC cycle of STORE r4,[2] -> no write strobe observed, state IDLE, pc=0, regs all 0; subsequent LOAD [2] returns 0.
- PC wrap / start handling: 16 NOPs, no HALT -> pc sequences 15 -> 0; toggling start while running changes nothing; in HALT, start is ignored.

Source files
------------

// File: rtl/cpu_control_unit.sv
// Multi-cycle fetch/execute controller: PC, IR, 8x4 register file, 4-bit ALU.
// Ports: clk/reset, start, instr (ROM at pc), dm_* memory side, dbg_sel/dbg_data, halted.
module cpu_control_unit #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 4,
  parameter int PC_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [11:0]           instr,
  output logic [PC_WIDTH-1:0]   pc,
  output logic [ADDR_WIDTH-1:0] dm_address,
  output logic [DATA_WIDTH-1:0] dm_write_data,
  output logic                  dm_write_enable,
  output logic                  dm_read_enable,
  input  logic [DATA_WIDTH-1:0] dm_read_data,
  input  logic [2:0]            dbg_sel,
  output logic [DATA_WIDTH-1:0] dbg_data,
  output logic                  halted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_MEM_WAIT,
    S_HALT
  } state_t;

  state_t state, state_nxt;

  logic [11:0]           ir;
  logic [DATA_WIDTH-1:0] regs [8];

  logic [2:0] op, rd, rs1, rs2;
  logic [3:0] imm;

  assign op  = ir[11:9];
  assign rd  = ir[8:6];
  assign rs1 = ir[5:3];
  assign rs2 = ir[2:0];
  assign imm = ir[3:0];

  logic is_load, is_store, is_add;
  logic is_sub, is_ldi, is_halt;

  assign is_load  = (op == 3'b001);
  assign is_store = (op == 3'b010);
  assign is_add   = (op == 3'b011);
  assign is_sub   = (op == 3'b100);
  assign is_ldi   = (op == 3'b101);
  assign is_halt  = (op == 3'b111);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:     if (start) state_nxt = S_FETCH;
      S_FETCH:    state_nxt = S_EXEC;
      S_EXEC: begin
        unique case (1'b1)
          is_load: state_nxt = S_MEM_WAIT;
          is_halt: state_nxt = S_HALT;
          default: state_nxt = S_FETCH;
        endcase
      end
      S_MEM_WAIT: state_nxt = S_FETCH;
      S_HALT:     state_nxt = S_HALT;
      default:    state_nxt = S_IDLE;
    endcase
  end

  logic                  reg_we;
  logic [DATA_WIDTH-1:0] reg_wd;

  // ALU and load writeback share a single register write port.
  always_comb begin
    reg_we = 1'b0;
    reg_wd = '0;
    if (state == S_EXEC) begin
      unique case (1'b1)
        is_add: begin
          reg_we = 1'b1;
          reg_wd = regs[rs1] + regs[rs2];
        end
        is_sub: begin
          reg_we = 1'b1;
          reg_wd = regs[rs1] - regs[rs2];
        end
        is_ldi: begin
          reg_we = 1'b1;
          reg_wd = DATA_WIDTH'(imm);
        end
        default: ;
      endcase
    end else if (state == S_MEM_WAIT) begin
      reg_we = 1'b1;
      reg_wd = dm_read_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= '0;
      ir <= '0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      if (state == S_FETCH) begin
        ir <= instr;
        pc <= pc + PC_WIDTH'(1);
      end
      if (reg_we) regs[rd] <= reg_wd;
    end
  end

  // Strobes are gated by reset so a reset during a STORE never writes.
  always_comb begin
    dm_address      = '0;
    dm_write_data   = '0;
    dm_write_enable = 1'b0;
    dm_read_enable  = 1'b0;
    if (!reset && state == S_EXEC) begin
      if (is_store) begin
        dm_write_enable = 1'b1;
        dm_address      = ADDR_WIDTH'(imm);
        dm_write_data   = regs[rd];
      end else if (is_load) begin
        dm_read_enable = 1'b1;
        dm_address     = ADDR_WIDTH'(imm);
      end
    end
  end

  assign dbg_data = regs[dbg_sel];
  assign halted   = (state == S_HALT);

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed bench for cpu_control_unit with a ROM and 16x4 data memory model.
// Exercises ALU ops, load/store, reset mid-store, PC wrap and start handling.
module tb_cpu_control_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [11:0] instr;
  logic [3:0]  pc;
  logic [3:0]  dm_address;
  logic [3:0]  dm_write_data;
  logic        dm_write_enable;
  logic        dm_read_enable;
  logic [3:0]  dm_read_data;
  logic [2:0]  dbg_sel = 3'd0;
  logic [3:0]  dbg_data;
  logic        halted;

  int checks = 0;
  int failures = 0;

  logic [11:0] rom [16];
  logic [3:0]  mem [16];

  int wr_cnt = 0, rd_cnt = 0, ovl_cnt = 0;
  int wr_addr = 0, wr_data = 0, rd_addr = 0;

  cpu_control_unit dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .instr          (instr),
    .pc             (pc),
    .dm_address     (dm_address),
    .dm_write_data  (dm_write_data),
    .dm_write_enable(dm_write_enable),
    .dm_read_enable (dm_read_enable),
    .dm_read_data   (dm_read_data),
    .dbg_sel        (dbg_sel),
    .dbg_data       (dbg_data),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  assign instr = rom[pc];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= 4'd0;
      dm_read_data <= 4'd0;
    end else begin
      if (dm_write_enable) mem[dm_address] <= dm_write_data;
      if (dm_read_enable) dm_read_data <= mem[dm_address];
    end
  end

  always @(negedge clk) begin
    if (dm_write_enable) begin
      wr_cnt  = wr_cnt + 1;
      wr_addr = int'(dm_address);
      wr_data = int'(dm_write_data);
    end
    if (dm_read_enable) begin
      rd_cnt  = rd_cnt + 1;
      rd_addr = int'(dm_address);
    end
    if (dm_read_enable && dm_write_enable) ovl_cnt = ovl_cnt + 1;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic get_reg(input int i, output int v);
    dbg_sel = 3'(i);
    #1;
    v = int'(dbg_data);
  endtask

  function automatic logic [11:0] ri(input logic [2:0] op,
                                     input logic [2:0] rd,
                                     input logic [3:0] imm);
    return {op, rd, 2'b00, imm};
  endfunction

  function automatic logic [11:0] rr(input logic [2:0] op,
                                     input logic [2:0] rd,
                                     input logic [2:0] rs1,
                                     input logic [2:0] rs2);
    return {op, rd, rs1, rs2};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = 12'h000;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  // Pulse start from IDLE, then count cycles from the first FETCH to HALT.
  task automatic run_prog(output int cyc);
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 0;
    while (!halted && cyc < 100) begin
      step();
      cyc++;
    end
    if (!halted) begin
      failures++;
      $display("FAIL run_timeout: got %0d cycles without halt", cyc);
    end
  endtask

  int v, cyc, w0, r0, o0;

  initial begin
    clear_rom();

    // Reset state
    do_reset();
    step();
    chk("rst_pc", int'(pc), 0);
    chk("rst_halted", int'(halted), 0);
    chk("rst_we", int'(dm_write_enable), 0);
    chk("rst_re", int'(dm_read_enable), 0);
    get_reg(3, v);
    chk("rst_r3", v, 0);

    // LDI/ADD with carry wrap
    rom[0] = ri(3'b101, 3'd1, 4'd9);
    rom[1] = ri(3'b101, 3'd2, 4'd8);
    rom[2] = rr(3'b011, 3'd3, 3'd1, 3'd2);
    rom[3] = 12'hE00;
    run_prog(cyc);
    chk("add_cycles", cyc, 8);
    chk("add_pc", int'(pc), 4);
    chk("add_halted", int'(halted), 1);
    get_reg(1, v);
    chk("add_r1", v, 9);
    get_reg(2, v);
    chk("add_r2", v, 8);
    get_reg(3, v);
    chk("add_r3", v, 1);

    // HALT ignores start
    start = 1'b1;
    repeat (4) step();
    start = 1'b0;
    chk("halt_pc", int'(pc), 4);
    chk("halt_stay", int'(halted), 1);

    // SUB with borrow wrap
    do_reset();
    clear_rom();
    rom[0] = ri(3'b101, 3'd1, 4'd2);
    rom[1] = ri(3'b101, 3'd2, 4'd5);
    rom[2] = rr(3'b100, 3'd0, 3'd1, 3'd2);
    rom[3] = 12'hE00;
    run_prog(cyc);
    get_reg(0, v);
    chk("sub_r0", v, 13);

    // STORE / LOAD round trip
    do_reset();
    clear_rom();
    rom[0] = ri(3'b101, 3'd4, 4'hA);
    rom[1] = ri(3'b010, 3'd4, 4'd7);
    rom[2] = ri(3'b001, 3'd5, 4'd7);
    rom[3] = 12'hE00;
    w0 = wr_cnt;
    r0 = rd_cnt;
    o0 = ovl_cnt;
    run_prog(cyc);
    chk("rt_cycles", cyc, 9);
    chk("rt_wr_cnt", wr_cnt - w0, 1);
    chk("rt_wr_addr", wr_addr, 7);
    chk("rt_wr_data", wr_data, 10);
    chk("rt_rd_cnt", rd_cnt - r0, 1);
    chk("rt_rd_addr", rd_addr, 7);
    chk("rt_overlap", ovl_cnt - o0, 0);
    get_reg(5, v);
    chk("rt_r5", v, 10);
    chk("rt_idle_addr", int'(dm_address), 0);

    // LOAD of a cleared address overwrites a nonzero register
    do_reset();
    clear_rom();
    rom[0] = ri(3'b101, 3'd6, 4'd5);
    rom[1] = ri(3'b001, 3'd6, 4'd3);
    rom[2] = 12'hE00;
    r0 = rd_cnt;
    run_prog(cyc);
    chk("ld0_cycles", cyc, 7);
    chk("ld0_rd_cnt", rd_cnt - r0, 1);
    get_reg(6, v);
    chk("ld0_r6", v, 0);

    // Reset during the EXEC cycle of a STORE
    do_reset();
    clear_rom();
    rom[0] = ri(3'b101, 3'd4, 4'd9);
    rom[1] = ri(3'b010, 3'd4, 4'd2);
    rom[2] = 12'hE00;
    w0 = wr_cnt;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    chk("rms_pre_we", int'(dm_write_enable), 1);
    reset = 1'b1;
    #1;
    chk("rms_we_gated", int'(dm_write_enable), 0);
    step();
    reset = 1'b0;
    step();
    step();
    chk("rms_wr_cnt", wr_cnt - w0, 0);
    chk("rms_pc", int'(pc), 0);
    chk("rms_halted", int'(halted), 0);
    get_reg(4, v);
    chk("rms_r4", v, 0);
    clear_rom();
    rom[0] = ri(3'b101, 3'd5, 4'd7);
    rom[1] = ri(3'b001, 3'd5, 4'd2);
    rom[2] = 12'hE00;
    run_prog(cyc);
    get_reg(5, v);
    chk("rms_ld_r5", v, 0);

    // NOP-only program wraps PC while start toggles
    do_reset();
    clear_rom();
    rom[5] = ri(3'b110, 3'd1, 4'd5);
    start = 1'b1;
    step();
    for (int i = 0; i < 30; i++) begin
      start = ~start;
      step();
    end
    chk("wrap_pc15", int'(pc), 15);
    step();
    step();
    chk("wrap_pc0", int'(pc), 0);
    step();
    step();
    chk("wrap_pc1", int'(pc), 1);
    chk("wrap_halted", int'(halted), 0);
    get_reg(1, v);
    chk("op110_r1", v, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
